apb_timer_slave: RTL
====================

Name: apb_timer_slave

Overview:
- APB completer holding a programmable down-counting timer with a prescaler and a maskable interrupt.
- Sits behind the AHB-to-APB bridge in one of the five 64 KB APB slave windows, on the bridge's PSELMx/PADDRMx/PENABLEMx/PWRITEMx/PWDATAMx outputs.
- Answers with PREADY/PRDATA/PSLVERR, and can insert programmable wait states so the bridge's ACCESS-phase stall path is exercised.

Parameters:
- ADDR_WIDTH, 32, width of PADDR; only PADDR[4:0] is decoded, upper bits are ignored because the bridge does window decode.
- DATA_WIDTH, 32, width of PWDATA/PRDATA; fixed at 32 for this block.
- WAIT_STATES, 0, number of PREADY-low cycles inserted in every access phase (0..15).
- PRESCALE_WIDTH, 16, width of the PRESCALE register.

Ports:
- PCLK  input  1  clock for the APB interface and all internal logic.
- PRESET  input  1  reset, synchronous, active-high.
- PSEL  input  1  slave select from the bridge.
- PENABLE  input  1  access-phase indicator.
- PADDR  input  ADDR_WIDTH  byte address.
- PWRITE  input  1  1 = write, 0 = read.
- PWDATA  input  DATA_WIDTH  write data.
- PREADY  output  1  transfer completion.
- PRDATA  output  DATA_WIDTH  read data, valid only while PREADY is high in the access phase.
- PSLVERR  output  1  error response, valid only while PREADY is high in the access phase.
- IRQ  output  1  level interrupt, equal to STATUS.EXP & CTRL.IRQ_EN.

Behaviour:
- Reset (PRESET=1 at a PCLK edge):
  - All registers clear to 0; the APB FSM returns to IDLE; the wait counter clears to 0.
  - PREADY=0, PRDATA=0, PSLVERR=0, IRQ=0.
  - A transfer in flight when reset asserts is abandoned; no register write commits.
- Register map (word offsets; PADDR[1:0] are ignored):
  - 0x00 CTRL, RW: bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN; other bits read 0.
  - 0x04 PRESCALE, RW, [PRESCALE_WIDTH-1:0].
  - 0x08 LOAD, RW, 32 bits. A write also copies PWDATA into COUNT in the same commit.
  - 0x0C COUNT, RO. A write returns PSLVERR=1 and has no effect.
  - 0x10 STATUS: bit0 EXP, write-1-to-clear.
  - Offsets 0x14..0x1C are unmapped: PSLVERR=1, read data 0, writes ignored.
- APB FSM, states IDLE / ACCESS_WAIT / ACCESS_DONE:
  - IDLE: on PSEL & ~PENABLE (setup phase), load wcnt=WAIT_STATES. Go to ACCESS_WAIT if WAIT_STATES>0, else ACCESS_DONE.
  - ACCESS_WAIT: PREADY=0; wcnt decrements each cycle while PSEL&PENABLE. At wcnt==1, go to ACCESS_DONE.
  - ACCESS_DONE: PREADY=1 combinationally while PSEL&PENABLE. The commit happens at this edge (write updates register; read data presented). Next state is IDLE.
  - PSEL dropping in ACCESS_WAIT (protocol violation): return to IDLE, no commit.
  - Back-to-back transfers (setup immediately after DONE) are supported with no idle cycle.
- PRDATA is driven only when PREADY=1 and ~PWRITE; it is 0 otherwise. PSLVERR is 0 whenever PREADY=0.
- Timer:
  - Prescaler pcnt counts 0..PRESCALE while EN=1; when pcnt==PRESCALE, tick=1 and pcnt wraps to 0. PRESCALE=0 gives a tick every cycle.
  - On tick with COUNT>0: COUNT decrements.
  - On tick with COUNT==0: EXP is set. If AUTO_RELOAD, COUNT<=LOAD; else EN clears and COUNT holds 0.
  - EN=0 freezes pcnt and COUNT. Any CTRL write that takes EN from 0 to 1 clears pcnt to 0.
- Simultaneous events:
  - A hardware EXP set in the same cycle as a W1C clear: set wins, EXP=1.
  - A LOAD write in the same cycle as a tick: the write wins and COUNT=PWDATA; the tick is dropped.
  - A CTRL write clearing EN in the same cycle as an expiry: the write value wins; EXP is still set.
- IRQ is derived from registered state only, so there is no combinational path from APB inputs.

Test Plan:
- Reset with WAIT_STATES=0: assert PRESET for 2 cycles mid-write of CTRL=0x7 -> CTRL reads 0x0, PREADY=0, IRQ=0 after release.
- WAIT_STATES=3: read LOAD after writing 0x1234 -> PREADY is low for exactly 3 access cycles and high on the 4th, PRDATA=0x00001234, PSLVERR=0.
- PRESCALE=2, LOAD=3, CTRL=0x5 (EN, IRQ_EN, no reload) -> COUNT steps 3,2,1,0 every 3 cycles. EXP=1 and IRQ=1 exactly 12 cycles after the EN commit. CTRL.EN reads 0.
- AUTO_RELOAD: PRESCALE=0, LOAD=1, CTRL=0x3 -> COUNT sequence 1,0,1,0; EXP is set on every second cycle. Writing STATUS=0x1 on a cycle with no expiry clears it. A W1C coincident with an expiry leaves EXP=1.
- Error paths: write COUNT=0xFFFF -> PSLVERR=1, COUNT unchanged. Read offset 0x18 -> PSLVERR=1, PRDATA=0.
- Back-to-back: write PRESCALE=5, then read PRESCALE in the immediately following setup phase -> PRDATA=0x5 with no idle cycle between transfers.

Source files
------------

// File: rtl/apb_timer_slave.sv
// apb_timer_slave
//   APB completer with a programmable down-counting timer, a prescaler and a
//   maskable level interrupt. Every access phase can be stretched by a fixed
//   number of wait states.
//
// Ports
//   PCLK     in   clock for the APB interface and the timer
//   PRESET   in   synchronous active-high reset
//   PSEL     in   slave select
//   PENABLE  in   access-phase indicator
//   PADDR    in   byte address, only [4:2] decoded
//   PWRITE   in   1 = write, 0 = read
//   PWDATA   in   write data
//   PREADY   out  transfer completion
//   PRDATA   out  read data, zero except during a completing read
//   PSLVERR  out  error response, only asserted with PREADY
//   IRQ      out  STATUS.EXP & CTRL.IRQ_EN
//
// Register map (word offsets)
//   0x00 CTRL      bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN
//   0x04 PRESCALE  [PRESCALE_WIDTH-1:0]
//   0x08 LOAD      write also loads COUNT
//   0x0C COUNT     read-only, writes error
//   0x10 STATUS    bit0 EXP, write-1-to-clear
//   0x14..0x1C     unmapped, error
//
// APB FSM
//   state           | meaning
//   ST_IDLE         | waiting for a setup phase
//   ST_ACCESS_WAIT  | access phase, PREADY held low while wcnt runs down
//   ST_ACCESS_DONE  | access phase, PREADY high, register commit on this edge

module apb_timer_slave #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int WAIT_STATES    = 0,
    parameter int PRESCALE_WIDTH = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic                  PWRITE,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic                  PREADY,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PSLVERR,
    output logic                  IRQ
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS_WAIT,
        ST_ACCESS_DONE
    } apb_state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    apb_state_t                state;
    logic [3:0]                wcnt;

    logic                      ctrl_en;
    logic                      ctrl_auto_reload;
    logic                      ctrl_irq_en;
    logic [PRESCALE_WIDTH-1:0] prescale;
    logic [DATA_WIDTH-1:0]     load_val;
    logic [DATA_WIDTH-1:0]     count;
    logic                      status_exp;
    logic [PRESCALE_WIDTH-1:0] pcnt;

    logic                      access;
    logic [2:0]                reg_sel;
    logic                      addr_err;
    logic                      wr_ctrl;
    logic                      wr_prescale;
    logic                      wr_load;
    logic                      wr_status;
    logic                      tick;
    logic                      expire;
    logic [DATA_WIDTH-1:0]     rd_data;
    logic                      unused_addr_bits;

    // Window decode is done upstream; only the word index matters here.
    assign unused_addr_bits = ^{PADDR[ADDR_WIDTH-1:5], PADDR[1:0]};

    assign reg_sel  = PADDR[4:2];
    assign access   = (state == ST_ACCESS_DONE) && PSEL && PENABLE;
    assign addr_err = (reg_sel > 3'd4) || (PWRITE && (reg_sel == 3'd3));

    assign wr_ctrl     = access && PWRITE && (reg_sel == 3'd0);
    assign wr_prescale = access && PWRITE && (reg_sel == 3'd1);
    assign wr_load     = access && PWRITE && (reg_sel == 3'd2);
    assign wr_status   = access && PWRITE && (reg_sel == 3'd4);

    assign tick   = ctrl_en && (pcnt == prescale);
    assign expire = tick && (count == '0);

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state <= ST_IDLE;
            wcnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (PSEL && !PENABLE) begin
                        wcnt  <= WAIT_INIT;
                        state <= (WAIT_STATES > 0) ? ST_ACCESS_WAIT : ST_ACCESS_DONE;
                    end
                end
                ST_ACCESS_WAIT: begin
                    // Losing PSEL mid-access abandons the transfer without a commit.
                    if (!PSEL) begin
                        state <= ST_IDLE;
                    end else if (PENABLE) begin
                        wcnt <= wcnt - 4'd1;
                        if (wcnt == 4'd1) begin
                            state <= ST_ACCESS_DONE;
                        end
                    end
                end
                ST_ACCESS_DONE: state <= ST_IDLE;
                default:        state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            ctrl_en          <= 1'b0;
            ctrl_auto_reload <= 1'b0;
            ctrl_irq_en      <= 1'b0;
            prescale         <= '0;
            load_val         <= '0;
            count            <= '0;
            status_exp       <= 1'b0;
            pcnt             <= '0;
        end else begin
            // Enabling restarts the prescaler so the first tick is a full period away.
            if (wr_ctrl && PWDATA[0] && !ctrl_en) begin
                pcnt <= '0;
            end else if (ctrl_en) begin
                pcnt <= tick ? '0 : pcnt + 1'b1;
            end

            // A CTRL write overrides the self-disable of a one-shot expiry.
            if (wr_ctrl) begin
                ctrl_en          <= PWDATA[0];
                ctrl_auto_reload <= PWDATA[1];
                ctrl_irq_en      <= PWDATA[2];
            end else if (expire && !ctrl_auto_reload) begin
                ctrl_en <= 1'b0;
            end

            if (wr_prescale) begin
                prescale <= PWDATA[PRESCALE_WIDTH-1:0];
            end

            if (wr_load) begin
                load_val <= PWDATA;
            end

            // LOAD write beats a coincident tick; the tick is simply lost.
            if (wr_load) begin
                count <= PWDATA;
            end else if (tick) begin
                if (count != '0) begin
                    count <= count - 1'b1;
                end else if (ctrl_auto_reload) begin
                    count <= load_val;
                end
            end

            // Hardware set beats software clear.
            if (expire) begin
                status_exp <= 1'b1;
            end else if (wr_status && PWDATA[0]) begin
                status_exp <= 1'b0;
            end
        end
    end

    always_comb begin
        rd_data = '0;
        case (reg_sel)
            3'd0:    rd_data[2:0] = {ctrl_irq_en, ctrl_auto_reload, ctrl_en};
            3'd1:    rd_data[PRESCALE_WIDTH-1:0] = prescale;
            3'd2:    rd_data = load_val;
            3'd3:    rd_data = count;
            3'd4:    rd_data[0] = status_exp;
            default: rd_data = '0;
        endcase
    end

    assign PREADY  = access;
    assign PRDATA  = (access && !PWRITE) ? rd_data : '0;
    assign PSLVERR = access && addr_err;
    assign IRQ     = status_exp && ctrl_irq_en;

endmodule
